// File: rtl/controller_responder.sv
// controller_responder
// Device-side end of a serial gamepad link. Emulates a shift-register
// controller: the button vector is loaded while the host latch is high.
// After the latch falls, one button is shifted per contCLK rising edge.
// Buttons are driven onto contRead as active-low wire levels.
//
// Ports
//   PCLK        fabric clock, all logic on the rising edge
//   RESET       synchronous active-high reset
//   buttons     button state (1 = pressed), bit 0 is sent first
//   contWrite   host latch (asynchronous to PCLK)
//   contCLK     host shift clock (asynchronous to PCLK)
//   contRead    serial data to host, low = pressed
//   frame_done  one-cycle pulse when the last bit has been shifted
//   overrun     sticky flag: contCLK rise seen after the frame completed
//   bit_index   bits shifted so far in the current frame
//
// Optional build macro: CONTROLLER_RESPONDER_GLITCH_FILTER_EN
//   When defined, a filter stage after each synchroniser only accepts a
//   level that was seen on two consecutive samples. This rejects
//   single-cycle glitches and adds one cycle of detection latency.

module controller_responder #(
  parameter int NUM_BITS = 16
) (
  input  logic                            PCLK,
  input  logic                            RESET,
  input  logic [NUM_BITS-1:0]             buttons,
  input  logic                            contWrite,
  input  logic                            contCLK,
  output logic                            contRead,
  output logic                            frame_done,
  output logic                            overrun,
  output logic [$clog2(NUM_BITS+1)-1:0]   bit_index
);

  localparam int BW = $clog2(NUM_BITS+1);
  localparam logic [BW-1:0] LAST_IDX = BW'(NUM_BITS);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LATCHED,
    ST_SHIFT,
    ST_DONE
  } state_e;

  // Synchroniser, optional filter and previous-value flops.
  logic wr_s1_q, wr_s2_q, wr_prev_q;
  logic ck_s1_q, ck_s2_q, ck_prev_q;
  logic wr_lvl, ck_lvl;

`ifdef CONTROLLER_RESPONDER_GLITCH_FILTER_EN
  logic wr_flt_q, ck_flt_q;
  assign wr_lvl = wr_flt_q;
  assign ck_lvl = ck_flt_q;
`else
  assign wr_lvl = wr_s2_q;
  assign ck_lvl = ck_s2_q;
`endif

  always_ff @(posedge PCLK) begin
    if (RESET) begin
      wr_s1_q   <= 1'b0;
      wr_s2_q   <= 1'b0;
      wr_prev_q <= 1'b0;
      ck_s1_q   <= 1'b0;
      ck_s2_q   <= 1'b0;
      ck_prev_q <= 1'b0;
`ifdef CONTROLLER_RESPONDER_GLITCH_FILTER_EN
      wr_flt_q  <= 1'b0;
      ck_flt_q  <= 1'b0;
`endif
    end else begin
      wr_s1_q   <= contWrite;
      wr_s2_q   <= wr_s1_q;
      ck_s1_q   <= contCLK;
      ck_s2_q   <= ck_s1_q;
`ifdef CONTROLLER_RESPONDER_GLITCH_FILTER_EN
      // Stage 1 and stage 2 agreeing means the level was seen on two
      // consecutive samples. Otherwise the previously accepted level holds.
      if (wr_s1_q == wr_s2_q) wr_flt_q <= wr_s2_q;
      if (ck_s1_q == ck_s2_q) ck_flt_q <= ck_s2_q;
`endif
      wr_prev_q <= wr_lvl;
      ck_prev_q <= ck_lvl;
    end
  end

  logic wr_rise, wr_fall, ck_rise;
  assign wr_rise =  wr_lvl & ~wr_prev_q;
  assign wr_fall = ~wr_lvl &  wr_prev_q;
  assign ck_rise =  ck_lvl & ~ck_prev_q;

  // Frame state machine.
  state_e              state_q, state_d;
  logic [NUM_BITS-1:0] sreg_q, sreg_d;
  logic [BW-1:0]       idx_q, idx_d;
  logic                done_q, done_d;
  logic                ovr_q, ovr_d;

  always_ff @(posedge PCLK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      sreg_q  <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    ovr_d   = ovr_q;
    // A latch rise restarts the frame from any state. It wins over a
    // contCLK rise detected in the same cycle, which is dropped.
    if (wr_rise) begin
      state_d = ST_LATCHED;
      sreg_d  = buttons;
      idx_d   = '0;
      ovr_d   = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: ;
        ST_LATCHED: begin
          sreg_d = buttons;
          idx_d  = '0;
          // A contCLK edge that coincides with the latch fall is ignored here.
          if (wr_fall) state_d = ST_SHIFT;
        end
        ST_SHIFT: begin
          if (ck_rise) begin
            sreg_d = {1'b1, sreg_q[NUM_BITS-1:1]};
            idx_d  = idx_q + BW'(1);
            if (idx_q + BW'(1) == LAST_IDX) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (ck_rise) ovr_d = 1'b1;
        end
      endcase
    end
  end

  assign contRead   = (state_q == ST_IDLE) ? 1'b1 : ~sreg_q[0];
  assign frame_done = done_q;
  assign overrun    = ovr_q;
  assign bit_index  = idx_q;

endmodule
